voice_ram_arbiter: RTL and testbench

Controller and arbiter for the single-port, masked-write voice-state RAM in the synth core. It shares the RAM between two requesters: port A, the MIDI event handler doing note-on/off writes, and port B, the voice render sequencer doing per-sample read/modify traffic. After every reset it clears the whole RAM, because the RAM's own reset does not touch its contents. Sits between the MIDI parser/voice sequencer and the RAM instance in the synth top.

---
 rtl/voice_ram_arbiter_if.sv | 48 ++++
 rtl/voice_ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_voice_ram_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/voice_ram_arbiter_if.sv
// Voice-state RAM arbiter bus: two requester ports plus the RAM side.
// slave = arbiter view, master = requester/RAM environment view.
interface voice_ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [DATA_WIDTH-1:0] a_mask;
  logic                  a_ack;
  logic [DATA_WIDTH-1:0] a_rdata;
  logic                  a_rvalid;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_din;
  logic [DATA_WIDTH-1:0] b_mask;
  logic                  b_ack;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  b_rvalid;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_mask;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_din, a_mask,
    output a_ack, a_rdata, a_rvalid,
    input  b_req, b_we, b_addr, b_din, b_mask,
    output b_ack, b_rdata, b_rvalid,
    output ram_addr, ram_din, ram_mask, ram_we,
    input  ram_dout
  );

  modport master (
    output a_req, a_we, a_addr, a_din, a_mask,
    input  a_ack, a_rdata, a_rvalid,
    output b_req, b_we, b_addr, b_din, b_mask,
    input  b_ack, b_rdata, b_rvalid,
    input  ram_addr, ram_din, ram_mask, ram_we,
    output ram_dout
  );
endinterface

// File: rtl/voice_ram_arbiter.sv
// Voice-state RAM arbiter: clears RAM after reset, then arbitrates
// port A (MIDI) and port B (render) onto a single-port masked RAM.
// Ports: i_clk, i_reset_n, bus (voice_ram_arbiter_if.slave),
// o_init_busy. Optional macro VOICE_ARB_RR_EN selects round-robin
// contention instead of B priority with STARVE_LIMIT forcing.
module voice_ram_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  voice_ram_arbiter_if.slave bus,
  output logic               o_init_busy
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  init_busy;

  logic                  gnt_a;
  logic                  gnt_b;
  logic                  rd_a;
  logic                  rd_b;

  logic [DATA_WIDTH-1:0] a_rdata;
  logic [DATA_WIDTH-1:0] b_rdata;
  logic                  a_rvalid;
  logic                  b_rvalid;

`ifdef VOICE_ARB_RR_EN
  // Set when B was the most recent grant; B loses next contention.
  logic last_b;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve;
`endif

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == RUN) begin
      unique case (1'b1)
        (bus.a_req && bus.b_req): begin
`ifdef VOICE_ARB_RR_EN
          gnt_a = last_b;
`else
          gnt_a = (starve == LIMIT);
`endif
          gnt_b = ~gnt_a;
        end
        (bus.a_req && !bus.b_req): gnt_a = 1'b1;
        (!bus.a_req && bus.b_req): gnt_b = 1'b1;
        default: ;
      endcase
    end
  end

  assign rd_a = gnt_a & ~bus.a_we;
  assign rd_b = gnt_b & ~bus.b_we;

  // Reset gates the sweep write so the RAM sees no write while held.
  always_comb begin
    bus.ram_addr = last_addr;
    bus.ram_din  = '0;
    bus.ram_mask = '0;
    bus.ram_we   = 1'b0;
    if (state == CLEAR) begin
      bus.ram_addr = clr_cnt;
      bus.ram_mask = '1;
      bus.ram_we   = i_reset_n;
    end else if (gnt_a) begin
      bus.ram_addr = bus.a_addr;
      bus.ram_din  = bus.a_din;
      bus.ram_mask = bus.a_mask;
      bus.ram_we   = bus.a_we;
    end else if (gnt_b) begin
      bus.ram_addr = bus.b_addr;
      bus.ram_din  = bus.b_din;
      bus.ram_mask = bus.b_mask;
      bus.ram_we   = bus.b_we;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      init_busy <= 1'b1;
      last_addr <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
`ifdef VOICE_ARB_RR_EN
      last_b    <= 1'b0;
`else
      starve    <= '0;
`endif
    end else begin
      last_addr <= bus.ram_addr;
      a_rvalid  <= rd_a;
      b_rvalid  <= rd_b;
      if (rd_a) a_rdata <= bus.ram_dout;
      if (rd_b) b_rdata <= bus.ram_dout;
      unique case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == '1) begin
            state     <= RUN;
            init_busy <= 1'b0;
          end
        end
        RUN: begin
`ifdef VOICE_ARB_RR_EN
          if (gnt_a)      last_b <= 1'b0;
          else if (gnt_b) last_b <= 1'b1;
`else
          // Counts only B wins that leave A waiting.
          if (!bus.a_req || gnt_a) starve <= '0;
          else if (gnt_b)          starve <= starve + 4'd1;
`endif
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign bus.a_ack    = gnt_a;
  assign bus.b_ack    = gnt_b;
  assign bus.a_rdata  = a_rdata;
  assign bus.b_rdata  = b_rdata;
  assign bus.a_rvalid = a_rvalid;
  assign bus.b_rvalid = b_rvalid;
  assign o_init_busy  = init_busy;

endmodule

// File: tb/tb_voice_ram_arbiter.sv
// Directed bench for voice_ram_arbiter, ADDR_WIDTH=4.
// Includes a masked-write RAM model with combinational read.
module tb_voice_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_busy;

  int checks = 0;
  int failures = 0;

  voice_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  voice_ram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus),
    .o_init_busy(init_busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];

  always @(posedge clk)
    if (bus.ram_we)
      mem[bus.ram_addr] <= (mem[bus.ram_addr] & ~bus.ram_mask)
                         | (bus.ram_din & bus.ram_mask);

  assign bus.ram_dout = mem[bus.ram_addr];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

  logic [9:0] pat;
  logic [3:0] hold_addr;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd3;
    bus.a_din = 8'hA5; bus.a_mask = 8'h0F;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0;
    bus.b_din = '0; bus.b_mask = '0;

    @(negedge clk);
    check("rst_a_ack", bus.a_ack, 0);
    check("rst_b_ack", bus.b_ack, 0);
    check("rst_a_rvalid", bus.a_rvalid, 0);
    check("rst_b_rvalid", bus.b_rvalid, 0);
    check("rst_a_rdata", bus.a_rdata, 0);
    check("rst_b_rdata", bus.b_rdata, 0);
    check("rst_busy", init_busy, 1);
    check("rst_ram_we", bus.ram_we, 0);

    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("sweep_busy", init_busy, 1);
      check("sweep_we", bus.ram_we, 1);
      check("sweep_addr", bus.ram_addr, i);
      check("sweep_din", bus.ram_din, 0);
      check("sweep_mask", bus.ram_mask, 8'hFF);
      check("sweep_a_ack", bus.a_ack, 0);
    end

    @(negedge clk);
    check("run_busy", init_busy, 0);
    check("run_a_ack", bus.a_ack, 1);
    check("run_b_ack", bus.b_ack, 0);
    check("run_addr", bus.ram_addr, 3);
    check("run_din", bus.ram_din, 8'hA5);
    check("run_mask", bus.ram_mask, 8'h0F);
    check("run_we", bus.ram_we, 1);

    tick();
    bus.a_we = 1'b0;
    @(negedge clk);
    check("rd_a_ack", bus.a_ack, 1);
    check("rd_we", bus.ram_we, 0);
    check("wr_no_rvalid", bus.a_rvalid, 0);
    tick();
    bus.a_req = 1'b0;
    @(negedge clk);
    check("rd_a_rvalid", bus.a_rvalid, 1);
    check("rd_a_rdata", bus.a_rdata, 8'h05);
    check("rd_a_ack_low", bus.a_ack, 0);
    tick();
    @(negedge clk);
    check("rd_a_rvalid_end", bus.a_rvalid, 0);
    check("rd_a_rdata_hold", bus.a_rdata, 8'h05);

    tick();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd7;
    bus.a_din = 8'h3C; bus.a_mask = 8'hFF;
    @(negedge clk);
    check("w7_a_ack", bus.a_ack, 1);
    tick();
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 4'd7;
    @(negedge clk);
    check("r7_b_ack", bus.b_ack, 1);
    check("r7_a_ack", bus.a_ack, 0);
    tick();
    bus.b_req = 1'b0;
    @(negedge clk);
    check("r7_b_rvalid", bus.b_rvalid, 1);
    check("r7_b_rdata", bus.b_rdata, 8'h3C);
    check("r7_a_rvalid", bus.a_rvalid, 0);
    tick();
    @(negedge clk);
    check("r7_b_rvalid_end", bus.b_rvalid, 0);

`ifdef VOICE_ARB_RR_EN
    // Last grant was B (the read), so A takes the first contention.
    pat = 10'b01_0101_0101;
    hold_addr = 4'd2;
`else
    pat = 10'b10_0001_0000;
    hold_addr = 4'd1;
`endif
    tick();
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 4'd1;
    bus.a_din = 8'h11; bus.a_mask = 8'hFF;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 4'd2;
    bus.b_din = 8'h22; bus.b_mask = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cont_a_ack", bus.a_ack, pat[i]);
      check("cont_b_ack", bus.b_ack, !pat[i]);
      check("cont_addr", bus.ram_addr, pat[i] ? 1 : 2);
      tick();
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(negedge clk);
    check("idle_we", bus.ram_we, 0);
    check("idle_addr", bus.ram_addr, hold_addr);
    check("idle_acks", {bus.a_ack, bus.b_ack}, 0);

    tick();
    rst_n = 1'b0;
    #1;
    check("rst2_busy", init_busy, 1);
    check("rst2_we", bus.ram_we, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("part_addr", bus.ram_addr, i);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("rst3_we", bus.ram_we, 0);
    check("rst3_busy", init_busy, 1);
    check("rst3_acks", {bus.a_ack, bus.b_ack}, 0);
    tick();
    rst_n = 1'b1;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 4'd3;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("resweep_addr", bus.ram_addr, i);
      check("resweep_we", bus.ram_we, 1);
      check("resweep_a_ack", bus.a_ack, 0);
    end
    @(negedge clk);
    check("rst4_pre_ack", bus.a_ack, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst4_a_ack", bus.a_ack, 0);
    check("rst4_rvalid", bus.a_rvalid, 0);
    tick();
    rst_n = 1'b1;
    bus.a_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst4_no_rvalid", bus.a_rvalid, 0);
      check("rst4_rdata", bus.a_rdata, 0);
      check("rst4_sweep", bus.ram_addr, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
